kid_motion: RTL and testbench

Frame-rate motion controller for the player character ("kid"). It consumes the four directional collision flags produced by the collision detector together with the keyboard controls. It produces the kid centre position (`kid_x`, `kid_y`) that feeds back into the collision detector and the sprite renderer. Motion includes walking, a ground jump plus one air jump, gravity with a terminal velocity, death below the playfield, and respawn.

---
 rtl/kid_pkg.sv | 22 ++
 rtl/kid_motion.sv | 170 +++++++++++++++++
 tb/tb_kid_motion.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/kid_pkg.sv
// rtl/kid_pkg.sv - kid motion state encoding and default screen/speed limits
package kid_pkg;

  typedef enum logic [1:0] {
    K_STAND = 2'd0,
    K_RISE  = 2'd1,
    K_FALL  = 2'd2,
    K_DEAD  = 2'd3
  } kid_state_t;

  localparam logic [9:0] KID_X_START  = 10'd60;
  localparam logic [9:0] KID_Y_START  = 10'd400;
  localparam logic [9:0] KID_X_STEP   = 10'd2;
  localparam logic [4:0] KID_JUMP_V   = 5'd7;
  localparam logic [4:0] KID_DJUMP_V  = 5'd5;
  localparam logic [4:0] KID_MAX_FALL = 5'd4;
  localparam logic [9:0] KID_X_MIN    = 10'd15;
  localparam logic [9:0] KID_X_MAX    = 10'd624;
  localparam logic [9:0] KID_Y_MIN    = 10'd15;
  localparam logic [9:0] KID_Y_DEATH  = 10'd470;

endpackage

// File: rtl/kid_motion.sv
// rtl/kid_motion.sv - frame-rate walk/jump/gravity/death controller for the kid
module kid_motion
  import kid_pkg::*;
#(
  parameter logic [9:0] X_START  = KID_X_START,
  parameter logic [9:0] Y_START  = KID_Y_START,
  parameter logic [9:0] X_STEP   = KID_X_STEP,
  parameter logic [4:0] JUMP_V   = KID_JUMP_V,
  parameter logic [4:0] DJUMP_V  = KID_DJUMP_V,
  parameter logic [4:0] MAX_FALL = KID_MAX_FALL,
  parameter logic [9:0] X_MIN    = KID_X_MIN,
  parameter logic [9:0] X_MAX    = KID_X_MAX,
  parameter logic [9:0] Y_MIN    = KID_Y_MIN,
  parameter logic [9:0] Y_DEATH  = KID_Y_DEATH
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       key_restart,
  input  logic       is_collision_x_right,
  input  logic       is_collision_x_left,
  input  logic       is_collision_y_down,
  input  logic       is_collision_y_up,
  output logic [9:0] kid_x,
  output logic [9:0] kid_y,
  output logic       facing,
  output logic       moving,
  output logic       dead,
  output logic [1:0] state
);

  kid_state_t        r_state, w_state_n;
  logic [9:0]        r_kid_x, w_x_n;
  logic [9:0]        r_kid_y, w_y_n;
  logic signed [4:0] r_vy, w_vy_n;
  logic [1:0]        r_jumps_left, w_jl_n;
  logic              r_facing, w_facing_n;
  logic              r_moving;
  logic              r_jump_prev, r_restart_prev;

  logic              w_jump_edge, w_restart_edge;
  logic [10:0]       w_x11, w_y11;
  logic [4:0]        w_rise_mag;
  logic [10:0]       w_rise_y, w_fall_y;
  logic signed [4:0] w_vy_inc;

  assign w_jump_edge    = key_jump & ~r_jump_prev;
  assign w_restart_edge = key_restart & ~r_restart_prev;
  assign w_x11          = {1'b0, r_kid_x};
  assign w_y11          = {1'b0, r_kid_y};
  assign w_rise_mag     = 5'd0 - $unsigned(r_vy);
  assign w_rise_y       = w_y11 - {6'd0, w_rise_mag};
  // vy is never negative while falling, so its low four bits are the full speed
  assign w_fall_y       = w_y11 + {7'd0, r_vy[3:0]};
  assign w_vy_inc       = r_vy + 5'sd1;

  always_comb begin
    w_state_n  = r_state;
    w_x_n      = r_kid_x;
    w_y_n      = r_kid_y;
    w_vy_n     = r_vy;
    w_jl_n     = r_jumps_left;
    w_facing_n = r_facing;

    if (r_state != K_DEAD) begin
      if (key_right && !key_left) begin
        w_facing_n = 1'b1;
        if (!is_collision_x_right && (w_x11 + {1'b0, X_STEP} <= {1'b0, X_MAX}))
          w_x_n = r_kid_x + X_STEP;
      end else if (key_left && !key_right) begin
        w_facing_n = 1'b0;
        if (!is_collision_x_left && (w_x11 >= {1'b0, X_MIN} + {1'b0, X_STEP}))
          w_x_n = r_kid_x - X_STEP;
      end
    end

    case (r_state)
      K_STAND: begin
        if (w_jump_edge) begin
          w_vy_n    = $signed(5'd0 - JUMP_V);
          w_jl_n    = 2'd1;
          w_state_n = K_RISE;
        end else if (!is_collision_y_down) begin
          w_vy_n    = 5'sd1;
          w_jl_n    = 2'd1;
          w_state_n = K_FALL;
        end
      end
      K_RISE: begin
        if (w_jump_edge && (r_jumps_left != 2'd0)) begin
          w_vy_n = $signed(5'd0 - DJUMP_V);
          w_jl_n = r_jumps_left - 2'd1;
        end else if (is_collision_y_up) begin
          w_vy_n    = 5'sd0;
          w_state_n = K_FALL;
        end else if (w_y11 < {1'b0, Y_MIN} + {6'd0, w_rise_mag}) begin
          w_y_n     = Y_MIN;
          w_vy_n    = 5'sd0;
          w_state_n = K_FALL;
        end else begin
          w_y_n  = w_rise_y[9:0];
          w_vy_n = w_vy_inc;
          if (w_vy_inc == 5'sd0)
            w_state_n = K_FALL;
        end
      end
      K_FALL: begin
        if (is_collision_y_down) begin
          w_vy_n    = 5'sd0;
          w_jl_n    = 2'd2;
          w_state_n = K_STAND;
        end else if (w_jump_edge && (r_jumps_left != 2'd0)) begin
          w_vy_n    = $signed(5'd0 - DJUMP_V);
          w_jl_n    = r_jumps_left - 2'd1;
          w_state_n = K_RISE;
        end else begin
          w_y_n  = w_fall_y[10] ? 10'h3FF : w_fall_y[9:0];
          w_vy_n = (r_vy >= $signed(MAX_FALL)) ? $signed(MAX_FALL) : w_vy_inc;
          if (w_fall_y > {1'b0, Y_DEATH})
            w_state_n = K_DEAD;
        end
      end
      K_DEAD: begin
        if (w_restart_edge) begin
          w_x_n     = X_START;
          w_y_n     = Y_START;
          w_vy_n    = 5'sd0;
          w_jl_n    = 2'd1;
          w_state_n = K_FALL;
        end
      end
      default: w_state_n = K_FALL;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state        <= K_FALL;
      r_kid_x        <= X_START;
      r_kid_y        <= Y_START;
      r_vy           <= 5'sd0;
      r_jumps_left   <= 2'd1;
      r_facing       <= 1'b1;
      r_moving       <= 1'b0;
      r_jump_prev    <= 1'b0;
      r_restart_prev <= 1'b0;
    end else if (frame_tick) begin
      r_state        <= w_state_n;
      r_kid_x        <= w_x_n;
      r_kid_y        <= w_y_n;
      r_vy           <= w_vy_n;
      r_jumps_left   <= w_jl_n;
      r_facing       <= w_facing_n;
      r_moving       <= (w_x_n != r_kid_x);
      r_jump_prev    <= key_jump;
      r_restart_prev <= key_restart;
    end
  end

  assign kid_x  = r_kid_x;
  assign kid_y  = r_kid_y;
  assign facing = r_facing;
  assign moving = r_moving;
  assign dead   = (r_state == K_DEAD);
  assign state  = r_state;

endmodule

// File: tb/tb_kid_motion.sv
// tb/tb_kid_motion.sv - directed scoreboard bench for kid_motion
module tb_kid_motion;
  import kid_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0, key_restart = 1'b0;
  logic       col_r = 1'b0, col_l = 1'b0, col_d = 1'b0, col_u = 1'b0;
  logic [9:0] kid_x, kid_y;
  logic       facing, moving, dead;
  logic [1:0] state;

  kid_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump), .key_restart(key_restart),
    .is_collision_x_right(col_r), .is_collision_x_left(col_l),
    .is_collision_y_down(col_d), .is_collision_y_up(col_u),
    .kid_x(kid_x), .kid_y(kid_y), .facing(facing), .moving(moving),
    .dead(dead), .state(state)
  );

  always #5 Clk = ~Clk;

  localparam int KX = 0, KY = 1, KS = 2, KF = 3, KM = 4, KD = 5;
  localparam int ST_STAND = 0, ST_RISE = 1, ST_FALL = 2, ST_DEAD = 3;

  typedef struct {
    int    kind;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] obs(int k);
    case (k)
      KX:      return {22'd0, kid_x};
      KY:      return {22'd0, kid_y};
      KS:      return {30'd0, state};
      KF:      return {31'd0, facing};
      KM:      return {31'd0, moving};
      default: return {31'd0, dead};
    endcase
  endfunction

  task automatic expv(int k, int v, string t);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.tag  = t;
    sb.push_back(e);
  endtask

  task automatic check_all();
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] o;
      e = sb.pop_front();
      o = obs(e.kind);
      checks++;
      assert (o === 32'(e.val)) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    check_all();
  endtask

  int rise_y [7] = '{403, 397, 392, 388, 385, 383, 382};
  int fall_y [5] = '{400, 401, 403, 406, 410};
  int ey, ev;
  bit died;

  initial begin
    #12;
    expv(KX, 60, "rst_x"); expv(KY, 400, "rst_y"); expv(KS, ST_FALL, "rst_state");
    expv(KF, 1, "rst_facing"); expv(KM, 0, "rst_moving"); expv(KD, 0, "rst_dead");
    check_all();
    @(negedge Clk);
    Reset = 1'b0;

    // free fall from reset: y += vy, then vy grows to MAX_FALL
    for (int i = 0; i < 5; i++) begin
      expv(KY, fall_y[i], "fall_from_reset_y");
      tick();
    end
    col_d = 1'b1;
    expv(KS, ST_STAND, "land_state"); expv(KY, 410, "land_y");
    tick();

    // ground jump held for 10 ticks: exactly one jump
    key_jump = 1'b1;
    expv(KS, ST_RISE, "jump_state"); expv(KY, 410, "jump_y_hold");
    tick();
    col_d = 1'b0;
    for (int i = 0; i < 7; i++) begin
      expv(KY, rise_y[i], "rise_y");
      expv(KS, (i == 6) ? ST_FALL : ST_RISE, "rise_state");
      tick();
    end
    expv(KY, 382, "held_fall_y0"); expv(KS, ST_FALL, "held_no_rejump");
    tick();
    expv(KY, 383, "held_fall_y1");
    tick();
    col_d = 1'b1;
    expv(KS, ST_STAND, "land2_state"); expv(KY, 383, "land2_y");
    tick();
    key_jump = 1'b0;
    tick();

    // air jump at rise tick 3, then a third press is ignored
    key_jump = 1'b1; expv(KY, 383, "dj_a"); tick();
    key_jump = 1'b0; expv(KY, 376, "dj_b"); tick();
    expv(KY, 370, "dj_c"); tick();
    key_jump = 1'b1; expv(KY, 370, "dj_press_y"); expv(KS, ST_RISE, "dj_press_state"); tick();
    key_jump = 1'b0; expv(KY, 365, "dj_vy5"); tick();
    key_jump = 1'b1; expv(KY, 361, "third_press_ignored"); tick();
    key_jump = 1'b0; expv(KY, 358, "dj_g"); tick();
    expv(KY, 356, "dj_h"); tick();
    expv(KY, 355, "dj_i"); expv(KS, ST_FALL, "dj_apex_state"); tick();
    expv(KS, ST_STAND, "land3_state"); tick();

    // ceiling hit during rise
    key_jump = 1'b1; expv(KY, 355, "up_a"); tick();
    key_jump = 1'b0; expv(KY, 348, "up_b"); tick();
    col_u = 1'b1; expv(KY, 348, "ceiling_y"); expv(KS, ST_FALL, "ceiling_state"); tick();
    col_u = 1'b0; expv(KS, ST_STAND, "land4_state"); tick();

    // horizontal blocking, facing, clamp at X_MAX
    key_right = 1'b1; col_r = 1'b1;
    expv(KX, 60, "blocked_r_x"); expv(KF, 1, "blocked_r_facing"); expv(KM, 0, "blocked_r_moving");
    tick();
    key_right = 1'b0; key_left = 1'b1; col_l = 1'b1;
    expv(KX, 60, "blocked_l_x"); expv(KF, 0, "blocked_l_facing");
    tick();
    key_left = 1'b0; col_l = 1'b0; key_right = 1'b1; col_r = 1'b0;
    expv(KX, 62, "walk_r_x"); expv(KF, 1, "walk_r_facing"); expv(KM, 1, "walk_r_moving");
    tick();
    for (int i = 0; i < 300; i++) tick();
    expv(KX, 624, "clamp_xmax"); expv(KM, 0, "clamp_moving");
    tick();
    key_left = 1'b1;
    expv(KX, 624, "both_keys_x"); expv(KF, 1, "both_keys_facing");
    tick();
    key_right = 1'b0;
    expv(KX, 622, "walk_l_x"); expv(KF, 0, "walk_l_facing");
    tick();
    key_left = 1'b0;

    // walk off the ledge and fall to death
    col_d = 1'b0;
    expv(KS, ST_FALL, "ledge_state"); expv(KY, 348, "ledge_y");
    tick();
    ey = 348; ev = 1; died = 1'b0;
    for (int i = 0; i < 60 && !died; i++) begin
      ey = ey + ev;
      ev = (ev >= 4) ? 4 : ev + 1;
      expv(KY, ey, "death_fall_y");
      if (ey > 470) begin
        expv(KS, ST_DEAD, "dead_state"); expv(KD, 1, "dead_flag");
        died = 1'b1;
      end
      tick();
    end
    checks++;
    assert (died) else begin
      errors++;
      $error("FAIL death_bound observed=%0d expected=%0d", died, 1);
    end

    key_right = 1'b1; key_jump = 1'b1;
    expv(KX, 622, "dead_x_frozen"); expv(KY, ey, "dead_y_frozen"); expv(KS, ST_DEAD, "dead_keys_ignored");
    tick();
    key_right = 1'b0; key_jump = 1'b0; key_restart = 1'b1;
    expv(KX, 60, "restart_x"); expv(KY, 400, "restart_y");
    expv(KS, ST_FALL, "restart_state"); expv(KD, 0, "restart_dead");
    tick();
    expv(KY, 400, "restart_vy0"); expv(KS, ST_FALL, "restart_held");
    tick();
    key_restart = 1'b0; key_right = 1'b1;
    expv(KX, 62, "post_restart_x"); expv(KY, 401, "post_restart_y"); expv(KM, 1, "post_restart_moving");
    tick();

    // asynchronous reset mid-fall, away from any clock edge
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    expv(KX, 60, "async_rst_x"); expv(KY, 400, "async_rst_y"); expv(KS, ST_FALL, "async_rst_state");
    expv(KM, 0, "async_rst_moving"); expv(KD, 0, "async_rst_dead");
    check_all();
    key_right = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
